// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int n;
    n = 0;
    while ((1 << n) < v) n++;
    return n;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done request bus between the operand registers and the divider.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_en;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             dbz;
  logic             ovf;

  modport master (
    output start, signed_en, dividend, divisor,
    input  ready, done, quo, rem, dbz, ovf
  );

  modport slave (
    input  start, signed_en, dividend, divisor,
    output ready, done, quo, rem, dbz, ovf
  );
endinterface

// File: rtl/restoring_step.sv
// One restoring-division bit: shift {A,Q} left, trial-subtract M, restore on a negative result.
module restoring_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_nxt,
  output logic [WIDTH-1:0] q_nxt
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           unused_a_msb;

  // A stays below M between steps, so its top bit is always clear on entry.
  assign unused_a_msb = a[WIDTH];

  always_comb begin
    shifted = {a[WIDTH-1:0], q[WIDTH-1]};
    trial   = shifted - {1'b0, m};
    if (trial[WIDTH]) begin
      a_nxt = shifted;
      q_nxt = {q[WIDTH-2:0], 1'b0};
    end else begin
      a_nxt = trial;
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// Signed/unsigned restoring divider, one quotient bit per clock; done pulses WIDTH+1 cycles
// after start is sampled (1 cycle for divide-by-zero); start is ignored while ready is low.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);
  localparam int CW = clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [WIDTH:0]   a_r, a_step;
  logic [WIDTH-1:0] q_r, q_step, m_r;
  logic [CW-1:0]    cnt_r;
  logic             sign_q, sign_m, dbz_pend, ovf_pend;
  logic [WIDTH-1:0] quo_r, rem_r;
  logic             dbz_r, ovf_r, done_r;
  logic [WIDTH-1:0] dividend_abs, divisor_abs;
  logic             neg_q_in, neg_m_in;

  assign neg_q_in     = bus.signed_en & bus.dividend[WIDTH-1];
  assign neg_m_in     = bus.signed_en & bus.divisor[WIDTH-1];
  // |MIN| = 2^(WIDTH-1) is representable when treated as unsigned.
  assign dividend_abs = neg_q_in ? -bus.dividend : bus.dividend;
  assign divisor_abs  = neg_m_in ? -bus.divisor  : bus.divisor;

  restoring_step #(.WIDTH(WIDTH)) u_step (
    .a     (a_r),
    .q     (q_r),
    .m     (m_r),
    .a_nxt (a_step),
    .q_nxt (q_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? S_FIX : S_ITER;
      S_ITER: if (cnt_r == CW'(1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= '0;
      q_r      <= '0;
      m_r      <= '0;
      cnt_r    <= '0;
      sign_q   <= 1'b0;
      sign_m   <= 1'b0;
      dbz_pend <= 1'b0;
      ovf_pend <= 1'b0;
      quo_r    <= '0;
      rem_r    <= '0;
      dbz_r    <= 1'b0;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          a_r      <= '0;
          q_r      <= dividend_abs;
          m_r      <= divisor_abs;
          cnt_r    <= CW'(WIDTH);
          sign_q   <= neg_q_in;
          sign_m   <= neg_m_in;
          dbz_pend <= (bus.divisor == '0);
          ovf_pend <= bus.signed_en && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
          dbz_r    <= 1'b0;
          ovf_r    <= 1'b0;
        end
        S_ITER: begin
          a_r   <= a_step;
          q_r   <= q_step;
          cnt_r <= cnt_r - CW'(1);
        end
        S_FIX: begin
          done_r <= 1'b1;
          dbz_r  <= dbz_pend;
          ovf_r  <= ovf_pend;
          if (dbz_pend) begin
            // Q still holds |dividend|; re-applying the sign returns the raw operand.
            quo_r <= '1;
            rem_r <= sign_q ? -q_r : q_r;
          end else begin
            quo_r <= (sign_q ^ sign_m) ? -q_r : q_r;
            rem_r <= sign_q ? -a_r[WIDTH-1:0] : a_r[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.done  = done_r;
  assign bus.quo   = quo_r;
  assign bus.rem   = rem_r;
  assign bus.dbz   = dbz_r;
  assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench: directed cases plus random sweeps at WIDTH=8 and 16 against an arithmetic model.
module tb_seq_restoring_divider;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_restoring_divider_if #(.WIDTH(8))  bus8 ();
  seq_restoring_divider_if #(.WIDTH(16)) bus16 ();

  seq_restoring_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  seq_restoring_divider #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors so far %0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division (truncating) with the corner-case rules layered on top.
  task automatic ref_div(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output bit z, output bit o);
    longint mask, sa, sb, qq, rr;
    mask = (64'sd1 <<< w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (sgn && a[w-1]) sa = sa - (64'sd1 <<< w);
    if (sgn && b[w-1]) sb = sb - (64'sd1 <<< w);
    z = (sb == 0);
    o = 1'b0;
    if (z) begin
      q = 32'(mask);
      r = 32'(longint'(a) & mask);
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      q  = 32'(qq & mask);
      r  = 32'(rr & mask);
      o  = sgn && (sa == -(64'sd1 <<< (w - 1))) && (sb == -1);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic sg,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 8) begin
      bus8.start = st; bus8.signed_en = sg; bus8.dividend = a[7:0]; bus8.divisor = b[7:0];
    end else begin
      bus16.start = st; bus16.signed_en = sg; bus16.dividend = a[15:0]; bus16.divisor = b[15:0];
    end
  endtask

  // field: 0 ready, 1 done, 2 quo, 3 rem, 4 dbz, 5 ovf
  function automatic logic [31:0] obs(input int w, input int field);
    logic [31:0] v;
    v = '0;
    if (w == 8) begin
      case (field)
        0: v = {31'd0, bus8.ready};
        1: v = {31'd0, bus8.done};
        2: v = {24'd0, bus8.quo};
        3: v = {24'd0, bus8.rem};
        4: v = {31'd0, bus8.dbz};
        default: v = {31'd0, bus8.ovf};
      endcase
    end else begin
      case (field)
        0: v = {31'd0, bus16.ready};
        1: v = {31'd0, bus16.done};
        2: v = {16'd0, bus16.quo};
        3: v = {16'd0, bus16.rem};
        4: v = {31'd0, bus16.dbz};
        default: v = {31'd0, bus16.ovf};
      endcase
    end
    return v;
  endfunction

  // Drives start at the current (negedge) point; returns just after the sampling edge.
  task automatic launch(input int w, input bit sg, input logic [31:0] a, input logic [31:0] b);
    drive(w, 1'b1, sg, a, b);
    @(posedge clk);
    #1;
    drive(w, 1'b0, 1'($urandom), $urandom, $urandom);
  endtask

  task automatic wait_done(input int w, input int k0, input bit sg,
                           input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eq, er;
    bit ez, eo, found;
    int k;
    ref_div(w, sg, a, b, eq, er, ez, eo);
    k = k0;
    found = 1'b0;
    while (!found && k < k0 + 40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (obs(w, 1) == 32'd1) found = 1'b1;
    end
    chk_val({tag, "_lat"}, k, ez ? 32'd1 : 32'(w + 1));
    chk_val({tag, "_quo"}, obs(w, 2), eq);
    chk_val({tag, "_rem"}, obs(w, 3), er);
    chk_val({tag, "_dbz"}, obs(w, 4), {31'd0, ez});
    chk_val({tag, "_ovf"}, obs(w, 5), {31'd0, eo});
  endtask

  task automatic do_op(input int w, input bit sg, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    int n;
    @(negedge clk);
    n = 0;
    while (obs(w, 0) != 32'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk_val({tag, "_ready_timeout"}, obs(w, 0), 32'd1);
    launch(w, sg, a, b);
    wait_done(w, 0, sg, a, b, tag);
    @(negedge clk);
    chk_val({tag, "_done_pulse"}, obs(w, 1), 32'd0);
    chk_val({tag, "_ready_after"}, obs(w, 0), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_val({tag, "_ready"}, obs(8, 0), 32'd1);
    chk_val({tag, "_done"},  obs(8, 1), 32'd0);
    chk_val({tag, "_quo"},   obs(8, 2), 32'd0);
    chk_val({tag, "_rem"},   obs(8, 3), 32'd0);
    chk_val({tag, "_dbz"},   obs(8, 4), 32'd0);
    chk_val({tag, "_ovf"},   obs(8, 5), 32'd0);
  endtask

  initial begin
    logic [31:0] mask, minv, a, b;
    int w, sel;
    bit sg;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(8, 1'b0, 1'b0, 0, 0);
    drive(16, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;

    do_op(8, 1, 32'h07, 32'h03, "s_7_3");
    do_op(8, 1, 32'hF9, 32'h03, "s_m7_3");
    do_op(8, 1, 32'h07, 32'hFD, "s_7_m3");
    do_op(8, 1, 32'hF9, 32'hFD, "s_m7_m3");
    do_op(8, 1, 32'h80, 32'hFF, "s_ovf");
    do_op(8, 0, 32'hF9, 32'h03, "u_f9_3");
    do_op(8, 0, 32'h25, 32'h00, "u_dbz");
    do_op(8, 1, 32'h25, 32'h00, "s_dbz");
    do_op(8, 0, 32'h80, 32'hFF, "u_80_ff");

    // Starts during ITER must be ignored; then a back-to-back start on the done/ready cycle.
    @(negedge clk);
    launch(8, 0, 32'd50, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(8, 1'b1, 1'b1, 32'h9C, 32'h03);
    end
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 0, 0);
    wait_done(8, 3, 0, 32'd50, 32'd5, "ignore");
    chk_val("b2b_ready", obs(8, 0), 32'd1);
    launch(8, 1, 32'h9C, 32'd7);
    wait_done(8, 0, 1, 32'h9C, 32'd7, "b2b");

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    launch(8, 0, 32'd200, 32'd3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    do_op(8, 0, 32'd100, 32'd7, "after_rst");

    for (int i = 0; i < 300; i++) begin
      w    = (i < 150) ? 8 : 16;
      mask = (w == 8) ? 32'hFF : 32'hFFFF;
      minv = (w == 8) ? 32'h80 : 32'h8000;
      sg   = 1'($urandom);
      sel  = $urandom_range(0, 9);
      a    = $urandom & mask;
      b    = $urandom & mask;
      if (sel == 0) b = 0;
      if (sel == 1) b = mask;
      if (sel == 2) a = minv;
      if (sel == 3) begin a = minv; b = mask; end
      if (sel == 4) b = $urandom_range(1, 5);
      do_op(w, sg, a, b, (w == 8) ? "rnd8" : "rnd16");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
